// File: rtl/id_stage_pipe_pkg.sv
// Shared constants for the instruction-decode stage: operand-select modes,
// immediate field widths and the default sprite base address.
package id_stage_pipe_pkg;

  typedef enum logic [1:0] {
    ALU_SRC_RR  = 2'b00,
    ALU_SRC_RI  = 2'b01,
    ALU_SRC_RS  = 2'b10,
    ALU_SRC_SPR = 2'b11
  } alu_src_e;

  localparam int ALU_SRC_W       = 2;
  localparam int I_IMM_W         = 16;
  localparam int J_IMM_W         = 26;
  localparam int SHAMT_W         = 5;
  localparam int SNUM_W          = 6;
  localparam int SPRITE_BASE_DEF = 'h0C00;

endpackage

// File: rtl/id_stage_pipe_if.sv
// Decode-stage bus: fetch-side instruction fields with valid/ready, write-back
// port, flush, and the registered ID/EX outputs with their own valid/ready.
interface id_stage_pipe_if #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int PC_W        = 32,
  parameter int STALL_CNT_W = 16
);
  import id_stage_pipe_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [REG_AW-1:0]      rs_addr;
  logic [REG_AW-1:0]      rt_addr;
  logic                   uses_rt;
  logic [REG_AW-1:0]      rd_addr;
  logic                   is_load;
  logic [ALU_SRC_W-1:0]   alu_src;
  logic                   branch;
  logic                   stack_op;
  logic                   sign_ext_sel;
  logic [I_IMM_W-1:0]     i_imm;
  logic [J_IMM_W-1:0]     j_imm;
  logic [SHAMT_W-1:0]     shamt;
  logic [SNUM_W-1:0]      snum;
  logic [PC_W-1:0]        pc_in;
  logic                   wb_en;
  logic [REG_AW-1:0]      wb_addr;
  logic [DATA_W-1:0]      wb_data;
  logic                   flush;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_W-1:0]      alu_in_1;
  logic [DATA_W-1:0]      alu_in_2;
  logic [REG_AW-1:0]      out_rd;
  logic                   out_is_load;
  logic [STALL_CNT_W-1:0] stall_cnt;

  modport master (
    output in_valid, rs_addr, rt_addr, uses_rt, rd_addr, is_load, alu_src,
           branch, stack_op, sign_ext_sel, i_imm, j_imm, shamt, snum, pc_in,
           wb_en, wb_addr, wb_data, flush, out_ready,
    input  in_ready, out_valid, alu_in_1, alu_in_2, out_rd, out_is_load, stall_cnt
  );

  modport slave (
    input  in_valid, rs_addr, rt_addr, uses_rt, rd_addr, is_load, alu_src,
           branch, stack_op, sign_ext_sel, i_imm, j_imm, shamt, snum, pc_in,
           wb_en, wb_addr, wb_data, flush, out_ready,
    output in_ready, out_valid, alu_in_1, alu_in_2, out_rd, out_is_load, stall_cnt
  );

endinterface

// File: rtl/id_stage_pipe_reg_file.sv
// Register file: two combinational read ports with write-back bypass, one
// synchronous write port; register 0 is hard-wired to zero.
module id_reg_file #(
  parameter int REG_AW = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data
);

  localparam int NUM_REGS = 2 ** REG_AW;

  logic [DATA_W-1:0] regs [NUM_REGS];

  // NOTE: clearing a memory on reset forbids RAM-macro mapping; it is kept here
  // because architectural state must read zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb_en && wb_addr != '0) begin
      regs[wb_addr] <= wb_data;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [REG_AW-1:0] addr);
    if (addr == '0)                   return '0;
    else if (wb_en && wb_addr == addr) return wb_data;
    else                              return regs[addr];
  endfunction

  always_comb begin
    rs_data = read_port(rs_addr);
    rt_data = read_port(rt_addr);
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Instruction-decode stage: register read, immediate sign-extension, ALU operand
// select, load-use hazard stall and a valid/ready ID/EX pipeline register.
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int PC_W        = 32,
  parameter int SPRITE_BASE = SPRITE_BASE_DEF,
  parameter int STACK_STEP  = 1,
  parameter int STALL_CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  id_stage_pipe_if.slave bus
);

  logic [DATA_W-1:0]      rs_data;
  logic [DATA_W-1:0]      rt_data;
  logic [DATA_W-1:0]      sext_imm;
  logic [DATA_W-1:0]      op_1;
  logic [DATA_W-1:0]      op_2;
  logic                   hazard;
  logic                   capture;

  logic                   valid_q;
  logic [DATA_W-1:0]      op_1_q;
  logic [DATA_W-1:0]      op_2_q;
  logic [REG_AW-1:0]      rd_q;
  logic                   is_load_q;
  logic [STALL_CNT_W-1:0] stall_q;

  id_reg_file #(
    .REG_AW (REG_AW),
    .DATA_W (DATA_W)
  ) u_reg_file (
    .clk     (clk),
    .rst     (rst),
    .rs_addr (bus.rs_addr),
    .rt_addr (bus.rt_addr),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .wb_en   (bus.wb_en),
    .wb_addr (bus.wb_addr),
    .wb_data (bus.wb_data)
  );

  always_comb begin
    sext_imm = bus.sign_ext_sel ? DATA_W'($signed(bus.j_imm))
                                : DATA_W'($signed(bus.i_imm));
  end

  // NOTE: both operands get a default before the case so no path leaves them
  // unassigned, which would infer latches.
  always_comb begin
    op_1 = rs_data;
    op_2 = rt_data;
    case (alu_src_e'(bus.alu_src))
      ALU_SRC_RR: ;
      ALU_SRC_RI: begin
        op_1 = bus.branch ? DATA_W'(bus.pc_in) : rs_data;
        op_2 = sext_imm;
      end
      ALU_SRC_RS: op_2 = bus.stack_op ? DATA_W'(STACK_STEP) : DATA_W'(bus.shamt);
      ALU_SRC_SPR: begin
        op_1 = DATA_W'(SPRITE_BASE);
        op_2 = DATA_W'(bus.snum);
      end
      default: ;
    endcase
  end

  // A load still in ID/EX cannot forward its data yet, so a dependent
  // instruction waits one cycle behind it.
  assign hazard = valid_q && is_load_q && (rd_q != '0) && bus.in_valid &&
                  ((rd_q == bus.rs_addr) || (bus.uses_rt && rd_q == bus.rt_addr));

  assign bus.in_ready = (!valid_q || bus.out_ready) && !hazard && !bus.flush;
  assign capture      = bus.in_valid && bus.in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      op_1_q    <= '0;
      op_2_q    <= '0;
      rd_q      <= '0;
      is_load_q <= 1'b0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (capture) begin
      valid_q   <= 1'b1;
      op_1_q    <= op_1;
      op_2_q    <= op_2;
      rd_q      <= bus.rd_addr;
      is_load_q <= bus.is_load;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         stall_q <= '0;
    else if (hazard && stall_q != '1) stall_q <= stall_q + 1'b1;
  end

  assign bus.out_valid   = valid_q;
  assign bus.alu_in_1    = op_1_q;
  assign bus.alu_in_2    = op_2_q;
  assign bus.out_rd      = rd_q;
  assign bus.out_is_load = is_load_q;
  assign bus.stall_cnt   = stall_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: directed vector table, hand-written
// hold/flush/hazard/reset sequences, and random traffic against a reference model.
module tb_id_stage_pipe;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int PC_W   = 32;
  localparam int SCW    = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_stage_pipe_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .PC_W(PC_W), .STALL_CNT_W(SCW)) bus ();

  id_stage_pipe #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .PC_W(PC_W),
    .SPRITE_BASE('h0C00), .STACK_STEP(1), .STALL_CNT_W(SCW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit        in_valid;
    bit [4:0]  rs, rt, rd;
    bit        uses_rt, is_load;
    bit [1:0]  alu_src;
    bit        branch, stack_op, sel;
    bit [15:0] i_imm;
    bit [25:0] j_imm;
    bit [4:0]  shamt;
    bit [5:0]  snum;
    bit [31:0] pc;
    bit        wb_en;
    bit [4:0]  wb_addr;
    bit [31:0] wb_data;
    bit        flush, out_ready;
  } stim_t;

  typedef struct {
    stim_t     s;
    bit        exp_ready, exp_valid, chk_ops;
    bit [31:0] exp_op1, exp_op2;
    bit [4:0]  exp_rd;
    bit        exp_load;
    int        exp_stall;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit [31:0] m_regs [32];
  bit        m_valid, m_load;
  bit [31:0] m_op1, m_op2;
  bit [4:0]  m_rd;
  int        m_stall;

  task automatic m_reset();
    foreach (m_regs[i]) m_regs[i] = 0;
    m_valid = 0; m_load = 0; m_op1 = 0; m_op2 = 0; m_rd = 0; m_stall = 0;
  endtask

  function automatic bit [31:0] m_read(stim_t s, bit [4:0] a);
    if (a == 0) return 0;
    if (s.wb_en && s.wb_addr == a) return s.wb_data;
    return m_regs[a];
  endfunction

  function automatic bit [31:0] m_sext(stim_t s);
    if (s.sel) return s.j_imm[25] ? (32'(s.j_imm) | 32'hFC00_0000) : 32'(s.j_imm);
    return s.i_imm[15] ? (32'(s.i_imm) | 32'hFFFF_0000) : 32'(s.i_imm);
  endfunction

  function automatic bit m_hazard(stim_t s);
    return s.in_valid && m_valid && m_load && m_rd != 0 &&
           (m_rd == s.rs || (s.uses_rt && m_rd == s.rt));
  endfunction

  function automatic bit m_ready(stim_t s);
    return !s.flush && !m_hazard(s) && (!m_valid || s.out_ready);
  endfunction

  task automatic m_update(stim_t s);
    bit        haz, acc;
    bit [31:0] a, b;
    haz = m_hazard(s);
    acc = s.in_valid && m_ready(s);
    case (s.alu_src)
      2'd0: begin a = m_read(s, s.rs); b = m_read(s, s.rt); end
      2'd1: begin a = s.branch ? s.pc : m_read(s, s.rs); b = m_sext(s); end
      2'd2: begin a = m_read(s, s.rs); b = s.stack_op ? 32'd1 : 32'(s.shamt); end
      default: begin a = 32'h0C00; b = 32'(s.snum); end
    endcase
    if (s.flush) m_valid = 0;
    else if (acc) begin
      m_valid = 1; m_op1 = a; m_op2 = b; m_rd = s.rd; m_load = s.is_load;
    end else if (s.out_ready) m_valid = 0;
    if (s.wb_en && s.wb_addr != 0) m_regs[s.wb_addr] = s.wb_data;
    if (haz && m_stall < 65535) m_stall++;
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    s.out_ready = 1;
    return s;
  endfunction

  function automatic stim_t instr(bit [1:0] mode, bit [4:0] rs, bit [4:0] rt, bit [4:0] rd);
    stim_t s;
    s = idle();
    s.in_valid = 1; s.uses_rt = 1; s.alu_src = mode;
    s.rs = rs; s.rt = rt; s.rd = rd;
    return s;
  endfunction

  task automatic apply(stim_t s);
    bus.in_valid = s.in_valid;   bus.rs_addr = s.rs;       bus.rt_addr = s.rt;
    bus.uses_rt = s.uses_rt;     bus.rd_addr = s.rd;       bus.is_load = s.is_load;
    bus.alu_src = s.alu_src;     bus.branch = s.branch;    bus.stack_op = s.stack_op;
    bus.sign_ext_sel = s.sel;    bus.i_imm = s.i_imm;      bus.j_imm = s.j_imm;
    bus.shamt = s.shamt;         bus.snum = s.snum;        bus.pc_in = s.pc;
    bus.wb_en = s.wb_en;         bus.wb_addr = s.wb_addr;  bus.wb_data = s.wb_data;
    bus.flush = s.flush;         bus.out_ready = s.out_ready;
  endtask

  // Called just after a falling edge; returns with the next falling edge reached.
  task automatic step(input stim_t s, output bit act_ready, output bit exp_ready);
    apply(s);
    #1;
    act_ready = bus.in_ready;
    exp_ready = m_ready(s);
    @(posedge clk);
    m_update(s);
    @(negedge clk);
  endtask

  task automatic cmp_model(string tag);
    check({tag, " out_valid"}, bus.out_valid, m_valid);
    if (m_valid) begin
      check({tag, " alu_in_1"}, bus.alu_in_1, m_op1);
      check({tag, " alu_in_2"}, bus.alu_in_2, m_op2);
      check({tag, " out_rd"}, bus.out_rd, m_rd);
      check({tag, " out_is_load"}, bus.out_is_load, m_load);
    end
    check({tag, " stall_cnt"}, bus.stall_cnt, m_stall);
  endtask

  function automatic vec_t mkv(stim_t s, bit r, bit v, bit c, bit [31:0] o1, bit [31:0] o2,
                               bit [4:0] rd, bit ld, int st);
    vec_t x;
    x.s = s; x.exp_ready = r; x.exp_valid = v; x.chk_ops = c;
    x.exp_op1 = o1; x.exp_op2 = o2; x.exp_rd = rd; x.exp_load = ld; x.exp_stall = st;
    return x;
  endfunction

  vec_t  tbl[$];
  stim_t s;
  bit    ar, er;

  initial begin
    // ---- directed vector table ----
    s = idle(); s.wb_en = 1; s.wb_addr = 3; s.wb_data = 32'h10;
    tbl.push_back(mkv(s, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(instr(2'b00, 3, 0, 1), 1, 1, 1, 32'h10, 0, 1, 0, 0));
    s = instr(2'b00, 5, 0, 2); s.wb_en = 1; s.wb_addr = 5; s.wb_data = 32'hAB;
    tbl.push_back(mkv(s, 1, 1, 1, 32'hAB, 0, 2, 0, 0));
    s = instr(2'b00, 0, 0, 3); s.wb_en = 1; s.wb_addr = 0; s.wb_data = 7;
    tbl.push_back(mkv(s, 1, 1, 1, 0, 0, 3, 0, 0));
    tbl.push_back(mkv(instr(2'b00, 0, 3, 4), 1, 1, 1, 0, 32'h10, 4, 0, 0));
    s = instr(2'b01, 3, 0, 5); s.branch = 1; s.pc = 32'h40; s.i_imm = 16'hFFFE;
    tbl.push_back(mkv(s, 1, 1, 1, 32'h40, 32'hFFFF_FFFE, 5, 0, 0));
    s = instr(2'b01, 3, 0, 6); s.sel = 1; s.j_imm = 26'h200_0000;
    tbl.push_back(mkv(s, 1, 1, 1, 32'h10, 32'hFE00_0000, 6, 0, 0));
    s = instr(2'b10, 5, 0, 7); s.stack_op = 1;
    tbl.push_back(mkv(s, 1, 1, 1, 32'hAB, 1, 7, 0, 0));
    s = instr(2'b10, 5, 0, 8); s.shamt = 7;
    tbl.push_back(mkv(s, 1, 1, 1, 32'hAB, 7, 8, 0, 0));
    s = instr(2'b11, 0, 0, 9); s.snum = 5;
    tbl.push_back(mkv(s, 1, 1, 1, 32'h0C00, 5, 9, 0, 0));
    s = instr(2'b00, 0, 0, 4); s.is_load = 1;
    tbl.push_back(mkv(s, 1, 1, 1, 0, 0, 4, 1, 0));
    s = instr(2'b00, 4, 0, 10); s.uses_rt = 0;
    tbl.push_back(mkv(s, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mkv(s, 1, 1, 1, 0, 0, 10, 0, 1));
    s = instr(2'b00, 5, 0, 6); s.is_load = 1;
    tbl.push_back(mkv(s, 1, 1, 1, 32'hAB, 0, 6, 1, 1));
    s = instr(2'b00, 3, 6, 11); s.uses_rt = 0;
    tbl.push_back(mkv(s, 1, 1, 1, 32'h10, 0, 11, 0, 1));
    s = instr(2'b00, 5, 0, 6); s.is_load = 1;
    tbl.push_back(mkv(s, 1, 1, 1, 32'hAB, 0, 6, 1, 1));
    s = instr(2'b00, 3, 6, 12);
    tbl.push_back(mkv(s, 0, 0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mkv(s, 1, 1, 1, 32'h10, 0, 12, 0, 2));

    // ---- reset ----
    m_reset();
    apply(idle());
    rst = 1'b1;
    #12;
    check("reset out_valid", bus.out_valid, 0);
    check("reset alu_in_1", bus.alu_in_1, 0);
    check("reset alu_in_2", bus.alu_in_2, 0);
    check("reset out_rd", bus.out_rd, 0);
    check("reset out_is_load", bus.out_is_load, 0);
    check("reset stall_cnt", bus.stall_cnt, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      step(tbl[i].s, ar, er);
      check($sformatf("vec%0d in_ready", i), ar, tbl[i].exp_ready);
      check($sformatf("vec%0d out_valid", i), bus.out_valid, tbl[i].exp_valid);
      if (tbl[i].chk_ops) begin
        check($sformatf("vec%0d alu_in_1", i), bus.alu_in_1, tbl[i].exp_op1);
        check($sformatf("vec%0d alu_in_2", i), bus.alu_in_2, tbl[i].exp_op2);
        check($sformatf("vec%0d out_rd", i), bus.out_rd, tbl[i].exp_rd);
        check($sformatf("vec%0d out_is_load", i), bus.out_is_load, tbl[i].exp_load);
      end
      check($sformatf("vec%0d stall_cnt", i), bus.stall_cnt, tbl[i].exp_stall);
    end

    // ---- back-pressure hold, then flush ----
    s = instr(2'b10, 5, 0, 13); s.stack_op = 1;
    step(s, ar, er);
    check("hold load alu_in_2", bus.alu_in_2, 1);
    s = instr(2'b00, 3, 3, 14); s.out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      step(s, ar, er);
      check($sformatf("hold%0d in_ready", k), ar, 0);
      check($sformatf("hold%0d out_valid", k), bus.out_valid, 1);
      check($sformatf("hold%0d alu_in_1", k), bus.alu_in_1, 32'hAB);
      check($sformatf("hold%0d alu_in_2", k), bus.alu_in_2, 1);
      check($sformatf("hold%0d out_rd", k), bus.out_rd, 13);
    end
    s.flush = 1;
    step(s, ar, er);
    check("flush in_ready", ar, 0);
    check("flush out_valid", bus.out_valid, 0);
    s.out_ready = 1;
    step(s, ar, er);
    check("flush empty in_ready", ar, 0);
    check("flush empty out_valid", bus.out_valid, 0);

    // ---- load-use hazard under back-pressure ----
    s = instr(2'b00, 5, 0, 7); s.is_load = 1;
    step(s, ar, er);
    check("lw7 out_is_load", bus.out_is_load, 1);
    s = instr(2'b00, 7, 0, 15); s.out_ready = 0;
    for (int k = 0; k < 2; k++) begin
      step(s, ar, er);
      check($sformatf("hzhold%0d in_ready", k), ar, 0);
      check($sformatf("hzhold%0d out_valid", k), bus.out_valid, 1);
      check($sformatf("hzhold%0d out_rd", k), bus.out_rd, 7);
      check($sformatf("hzhold%0d stall_cnt", k), bus.stall_cnt, 3 + k);
    end
    s.out_ready = 1;
    step(s, ar, er);
    check("hzbubble in_ready", ar, 0);
    check("hzbubble out_valid", bus.out_valid, 0);
    check("hzbubble stall_cnt", bus.stall_cnt, 5);
    step(s, ar, er);
    check("hzgo in_ready", ar, 1);
    check("hzgo out_rd", bus.out_rd, 15);

    // ---- randomized traffic against the model ----
    for (int n = 0; n < 400; n++) begin
      s.in_valid = ($urandom_range(0, 9) < 8);
      s.rs = 5'($urandom_range(0, 7));
      s.rt = 5'($urandom_range(0, 7));
      s.rd = 5'($urandom_range(0, 7));
      s.uses_rt = 1'($urandom);
      s.is_load = ($urandom_range(0, 2) == 0);
      s.alu_src = 2'($urandom);
      s.branch = 1'($urandom);
      s.stack_op = 1'($urandom);
      s.sel = 1'($urandom);
      s.i_imm = 16'($urandom);
      s.j_imm = 26'($urandom);
      s.shamt = 5'($urandom);
      s.snum = 6'($urandom);
      s.pc = $urandom;
      s.wb_en = 1'($urandom);
      s.wb_addr = 5'($urandom_range(0, 7));
      s.wb_data = $urandom;
      s.flush = ($urandom_range(0, 15) == 0);
      s.out_ready = ($urandom_range(0, 3) != 0);
      step(s, ar, er);
      check($sformatf("rnd%0d in_ready", n), ar, er);
      cmp_model($sformatf("rnd%0d", n));
    end

    // ---- asynchronous reset in the middle of traffic ----
    s = instr(2'b10, 5, 0, 9); s.out_ready = 0; s.wb_en = 1; s.wb_addr = 3; s.wb_data = 32'h55;
    step(s, ar, er);
    #2;
    rst = 1'b1;
    #1;
    check("midrst out_valid", bus.out_valid, 0);
    check("midrst alu_in_1", bus.alu_in_1, 0);
    check("midrst alu_in_2", bus.alu_in_2, 0);
    check("midrst stall_cnt", bus.stall_cnt, 0);
    m_reset();
    apply(idle());
    @(negedge clk);
    rst = 1'b0;
    s = instr(2'b00, 3, 5, 1);
    step(s, ar, er);
    check("postrst alu_in_1", bus.alu_in_1, 0);
    check("postrst alu_in_2", bus.alu_in_2, 0);
    cmp_model("postrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
